// File: rtl/fm_mod_pkg.sv
// Shared types and helpers for the FM phase modulator.
// Latency: n/a (types, constants and combinational helpers only).
// Backpressure: n/a.
package fm_mod_pkg;

    localparam int LUT_ADDR_BITS  = 8;
    localparam int PHASE_IDX_BITS = 10;

    // One IQ sample as it appears on the output bus: {Q[31:16], I[15:0]}.
    typedef struct packed {
        logic signed [15:0] q;
        logic signed [15:0] i;
    } iq_t;

    // The quarter-wave table covers quadrant 0 only; odd quadrants read it
    // mirrored. Because T[] uses half-bin centres, 255-a is simply ~a.
    function automatic logic [LUT_ADDR_BITS-1:0] quarter_addr(
        input logic [PHASE_IDX_BITS-1:0] p
    );
        return p[LUT_ADDR_BITS] ? ~p[LUT_ADDR_BITS-1:0] : p[LUT_ADDR_BITS-1:0];
    endfunction

    // The second half-turn is the negated first half-turn. Table magnitudes
    // never exceed 32767, so the negation cannot overflow.
    function automatic logic signed [15:0] fold_quadrant(
        input logic [1:0]  quad,
        input logic [15:0] mag
    );
        return quad[1] ? -$signed(mag) : $signed(mag);
    endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine table, 256 x 16 unsigned, two independent read ports.
// Latency: 1 cycle from address to registered data.
// Backpressure: en_i low holds both read registers.
//
// Ports:
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   en_i                 read enable (pipeline advance)
//   addr_a_i, addr_b_i   table indices
//   dat_a_o, dat_b_o     registered table entries
module quarter_sine_rom #(
    parameter int AMP = 32767
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic [7:0]  addr_a_i,
    input  logic [7:0]  addr_b_i,
    output logic [15:0] dat_a_o,
    output logic [15:0] dat_b_o
);

    localparam real PI = 3.14159265358979323846;

    logic [15:0] rom [256];
    logic [15:0] dat_a_q;
    logic [15:0] dat_b_q;

    // T[k] = round(AMP * sin(pi/2 * (k + 0.5) / 256)); evaluated at
    // elaboration so the table always tracks AMP.
    for (genvar k = 0; k < 256; k++) begin : g_tab
        localparam real ANG = PI / 2.0 * (real'(k) + 0.5) / 256.0;
        localparam int  VAL = $rtoi(real'(AMP) * $sin(ANG) + 0.5);
        assign rom[k] = 16'(VAL);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dat_a_q <= '0;
            dat_b_q <= '0;
        end else if (en_i) begin
            dat_a_q <= rom[addr_a_i];
            dat_b_q <= rom[addr_b_i];
        end
    end

    assign dat_a_o = dat_a_q;
    assign dat_b_o = dat_b_q;

endmodule

// File: rtl/fm_phase_mod.sv
// Streaming FM modulator: integrates samples into a phase and emits unit-amplitude IQ.
// Latency: beat accepted at edge k appears on m00 after edge k+2; 1 sample/clock.
// Backpressure: whole 3-stage pipe (phase included) freezes while m00 is stalled.
//
// Ports:
//   s00_axis_aclk / s00_axis_aresetn   clock, asynchronous active-low reset
//   s00_axis_*                         input samples, tdata[15:0] signed
//   m00_axis_*                         output IQ {Q[31:16], I[15:0]}, sideband
//                                      tstrb/tlast of the originating beat
module fm_phase_mod
    import fm_mod_pkg::*;
#(
    parameter int                    C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int                    C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int                    PHASE_BITS             = 32,
    parameter int                    DEV_SHIFT              = 14,
    parameter logic [PHASE_BITS-1:0] CARRIER_FCW            = '0,
    parameter int                    AMP                    = 32767
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic                                  s00_axis_tvalid,
    output logic                                  s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
    input  logic                                  s00_axis_tlast,
    output logic                                  m00_axis_tvalid,
    input  logic                                  m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
    output logic                                  m00_axis_tlast
);

    localparam int SW = C_S00_AXIS_TDATA_WIDTH / 8;

    logic                  clk;
    logic                  rst_n;
    logic                  en;
    logic                  accept;

    // S1: phase accumulator and sideband
    logic [PHASE_BITS-1:0] x_sext;
    logic [PHASE_BITS-1:0] inc;
    logic [PHASE_BITS-1:0] phase_d;
    logic [PHASE_BITS-1:0] phase_q;
    logic                  s1_vld_q;
    logic [SW-1:0]         s1_strb_q;
    logic                  s1_last_q;

    // S2: table read
    logic [PHASE_IDX_BITS-1:0] p_sin;
    logic [PHASE_IDX_BITS-1:0] p_cos;
    logic [15:0]               mag_sin;
    logic [15:0]               mag_cos;
    logic                      s2_vld_q;
    logic [1:0]                s2_quad_sin_q;
    logic [1:0]                s2_quad_cos_q;
    logic [SW-1:0]             s2_strb_q;
    logic                      s2_last_q;

    // S3: folded output
    iq_t                   iq_d;
    iq_t                   iq_q;
    logic                  m_vld_q;
    logic [SW-1:0]         m_strb_q;
    logic                  m_last_q;

    logic                  unused_tdata_hi;

    assign clk   = s00_axis_aclk;
    assign rst_n = s00_axis_aresetn;

    // The pipe moves whenever the output slot is free or being drained this
    // cycle, so accept and drain in the same cycle lose nothing.
    assign en              = m00_axis_tready || !m_vld_q;
    assign s00_axis_tready = en;
    assign accept          = s00_axis_tvalid && en;

    assign unused_tdata_hi = ^s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:16];

    // Increment wraps mod 2^PHASE_BITS; -32768 simply becomes a large
    // unsigned step, which is the same turn fraction.
    assign x_sext  = {{(PHASE_BITS-16){s00_axis_tdata[15]}}, s00_axis_tdata[15:0]};
    assign inc     = CARRIER_FCW + (x_sext << DEV_SHIFT);
    assign phase_d = phase_q + inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= '0;
            s1_vld_q  <= 1'b0;
            s1_strb_q <= '0;
            s1_last_q <= 1'b0;
        end else if (en) begin
            s1_vld_q <= s00_axis_tvalid;
            if (s00_axis_tvalid) begin
                phase_q   <= phase_d;
                s1_strb_q <= s00_axis_tstrb;
                s1_last_q <= s00_axis_tlast;
            end
        end
    end

    // cos(p) is sin a quarter-turn ahead; the 10-bit add wraps naturally.
    assign p_sin = phase_q[PHASE_BITS-1 -: PHASE_IDX_BITS];
    assign p_cos = p_sin + PHASE_IDX_BITS'(256);

    quarter_sine_rom #(
        .AMP (AMP)
    ) u_rom (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .en_i     (en),
        .addr_a_i (quarter_addr(p_sin)),
        .addr_b_i (quarter_addr(p_cos)),
        .dat_a_o  (mag_sin),
        .dat_b_o  (mag_cos)
    );

    // Quadrant bits travel alongside the ROM read so they line up with the
    // registered table data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q      <= 1'b0;
            s2_quad_sin_q <= '0;
            s2_quad_cos_q <= '0;
            s2_strb_q     <= '0;
            s2_last_q     <= 1'b0;
        end else if (en) begin
            s2_vld_q      <= s1_vld_q;
            s2_quad_sin_q <= p_sin[PHASE_IDX_BITS-1 -: 2];
            s2_quad_cos_q <= p_cos[PHASE_IDX_BITS-1 -: 2];
            s2_strb_q     <= s1_strb_q;
            s2_last_q     <= s1_last_q;
        end
    end

    always_comb begin
        iq_d   = '0;
        iq_d.q = fold_quadrant(s2_quad_sin_q, mag_sin);
        iq_d.i = fold_quadrant(s2_quad_cos_q, mag_cos);
    end

    // Data registers only load on real beats, so a bubble leaves the last
    // sample on the bus with tvalid low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld_q  <= 1'b0;
            iq_q     <= '0;
            m_strb_q <= '0;
            m_last_q <= 1'b0;
        end else if (en) begin
            m_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                iq_q     <= iq_d;
                m_strb_q <= s2_strb_q;
                m_last_q <= s2_last_q;
            end
        end
    end

    assign m00_axis_tvalid = m_vld_q;
    assign m00_axis_tdata  = C_M00_AXIS_TDATA_WIDTH'(iq_q);
    assign m00_axis_tstrb  = (C_M00_AXIS_TDATA_WIDTH/8)'(m_strb_q);
    assign m00_axis_tlast  = m_last_q;

endmodule

// File: tb/tb_fm_phase_mod.sv
// Scoreboard bench for fm_phase_mod: two instances (no carrier / quarter-turn carrier)
// share one input stream; an independent phase + sine model predicts every output beat.
module tb_fm_phase_mod;

    localparam real PI  = 3.14159265358979323846;
    localparam int  AMP = 32767;

    typedef struct packed {
        logic [31:0] dat;
        logic [3:0]  strb;
        logic        last;
    } beat_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_vld = 1'b0;
    logic [31:0] s_dat = '0;
    logic [3:0]  s_strb = '0;
    logic        s_last = 1'b0;
    logic        m_rdy = 1'b1;

    logic        s_rdy0, s_rdy1, m_vld0, m_vld1, m_last0, m_last1;
    logic [31:0] m_dat0, m_dat1;
    logic [3:0]  m_strb0, m_strb1;

    always #5 clk = ~clk;

    fm_phase_mod #(.CARRIER_FCW(32'd0)) dut0 (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis_tvalid  (s_vld),
        .s00_axis_tready  (s_rdy0),
        .s00_axis_tdata   (s_dat),
        .s00_axis_tstrb   (s_strb),
        .s00_axis_tlast   (s_last),
        .m00_axis_tvalid  (m_vld0),
        .m00_axis_tready  (m_rdy),
        .m00_axis_tdata   (m_dat0),
        .m00_axis_tstrb   (m_strb0),
        .m00_axis_tlast   (m_last0)
    );

    fm_phase_mod #(.CARRIER_FCW(32'h4000_0000)) dut1 (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis_tvalid  (s_vld),
        .s00_axis_tready  (s_rdy1),
        .s00_axis_tdata   (s_dat),
        .s00_axis_tstrb   (s_strb),
        .s00_axis_tlast   (s_last),
        .m00_axis_tvalid  (m_vld1),
        .m00_axis_tready  (m_rdy),
        .m00_axis_tdata   (m_dat1),
        .m00_axis_tstrb   (m_strb1),
        .m00_axis_tlast   (m_last1)
    );

    int          n_err = 0;
    int          n_chk = 0;
    int          cyc   = 0;
    beat_t       sb0[$];
    beat_t       sb1[$];
    logic [31:0] obs0[$];
    logic [31:0] obs1[$];
    logic [31:0] ph0 = '0;
    logic [31:0] ph1 = '0;
    logic        seen_first = 1'b0;
    logic        acc_seen   = 1'b0;
    int          first_cyc  = 0;
    int          acc_cyc    = 0;
    logic        stall_prev_vld = 1'b0;
    logic [31:0] stall_prev = '0;
    beat_t       w0, w1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lut_sin(input logic [9:0] p);
        int   k;
        int   t;
        real  v;
        k = p[8] ? 255 - int'(p[7:0]) : int'(p[7:0]);
        v = real'(AMP) * $sin(PI / 2.0 * (real'(k) + 0.5) / 256.0);
        t = $rtoi(v + 0.5);
        return p[9] ? 16'(-t) : 16'(t);
    endfunction

    function automatic logic [31:0] exp_iq(input logic [31:0] phase);
        logic [9:0] p;
        logic [9:0] pc;
        p  = phase[31:22];
        pc = p + 10'd256;
        return {lut_sin(p), lut_sin(pc)};
    endfunction

    task automatic clear_sb();
        sb0.delete();
        sb1.delete();
        obs0.delete();
        obs1.delete();
        ph0 = '0;
        ph1 = '0;
        seen_first = 1'b0;
        acc_seen = 1'b0;
        stall_prev_vld = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_vld = 1'b0;
        repeat (2) @(negedge clk);
        clear_sb();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drive one beat; the model advances exactly when the DUT will accept it.
    task automatic send(input logic [15:0] x, input logic last, input logic [3:0] strb);
        int          waited;
        int          xi;
        logic [31:0] inc;
        beat_t       b;
        waited = 0;
        s_vld  = 1'b1;
        s_dat  = {16'hA5A5, x};
        s_strb = strb;
        s_last = last;
        while (!(s_rdy0 && s_rdy1) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            n_chk++;
            n_err++;
            $display("FAIL send_timeout: s00_axis_tready stuck low for %0d cycles", waited);
        end else begin
            if (!acc_seen) begin
                acc_seen = 1'b1;
                acc_cyc  = cyc + 1;
            end
            xi  = int'($signed(x));
            inc = 32'(xi) << 14;
            ph0 = ph0 + inc;
            ph1 = ph1 + inc + 32'h4000_0000;
            b.strb = strb;
            b.last = last;
            b.dat  = exp_iq(ph0);
            sb0.push_back(b);
            b.dat  = exp_iq(ph1);
            sb1.push_back(b);
        end
        @(negedge clk);
        s_vld  = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_timeout: %0d/%0d beats never emitted", sb0.size(), sb1.size());
        end
        @(negedge clk);
    endtask

    // Output monitor: pops the scoreboard on every completed m00 handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_vld0 && !seen_first) begin
                seen_first = 1'b1;
                first_cyc  = cyc;
            end
            if (m_vld0 && m_rdy) begin
                if (sb0.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL dut0_extra: got 0x%08h expected no beat", m_dat0);
                end else begin
                    w0 = sb0.pop_front();
                    check("dut0_dat", m_dat0, w0.dat);
                    check("dut0_strb", {28'b0, m_strb0}, {28'b0, w0.strb});
                    check("dut0_last", {31'b0, m_last0}, {31'b0, w0.last});
                end
                obs0.push_back(m_dat0);
            end
            if (m_vld1 && m_rdy) begin
                if (sb1.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL dut1_extra: got 0x%08h expected no beat", m_dat1);
                end else begin
                    w1 = sb1.pop_front();
                    check("dut1_dat", m_dat1, w1.dat);
                    check("dut1_last", {31'b0, m_last1}, {31'b0, w1.last});
                end
                obs1.push_back(m_dat1);
            end
            if (m_vld0 && !m_rdy) begin
                check("stall_s_rdy", {31'b0, s_rdy0}, 32'd0);
                if (stall_prev_vld)
                    check("stall_stable", m_dat0, stall_prev);
                stall_prev     = m_dat0;
                stall_prev_vld = 1'b1;
            end else begin
                stall_prev_vld = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] qexp [4];
        qexp[0] = 32'h7FFF_FF9B;  // (I,Q) = (-101, 32767)
        qexp[1] = 32'hFF9B_8001;  // (-32767, -101)
        qexp[2] = 32'h8001_0065;  // (101, -32767)
        qexp[3] = 32'h0065_7FFF;  // (32767, 101)

        // Reset / idle
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_m_vld", {31'b0, m_vld0}, 32'd0);
        check("rst_m_dat", m_dat0, 32'd0);
        check("rst_m_strb", {28'b0, m_strb0}, 32'd0);
        check("rst_m_last", {31'b0, m_last0}, 32'd0);
        check("rst_m_vld1", {31'b0, m_vld1}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_s_rdy", {31'b0, s_rdy0}, 32'd1);
        check("idle_m_vld", {31'b0, m_vld0}, 32'd0);

        // DC zero
        do_reset();
        send(16'd0, 1'b0, 4'hF);
        send(16'd0, 1'b1, 4'h3);
        drain();
        check("dc_latency", 32'(first_cyc - acc_cyc), 32'd2);
        check("dc_count", 32'(obs0.size()), 32'd2);
        check("dc_iq0", obs0[0], 32'h0065_7FFF);
        check("dc_iq1", obs0[1], 32'h0065_7FFF);

        // Quarter-turn carrier (instance 1)
        do_reset();
        repeat (4) send(16'd0, 1'b0, 4'hF);
        drain();
        for (int i = 0; i < 4; i++)
            check($sformatf("quarter_iq%0d", i), obs1[i], qexp[i]);

        // Deviation up then back down, then full-scale negative samples
        do_reset();
        repeat (4) send(16'sd16384, 1'b0, 4'h1);
        drain();
        check("dev_up", obs0[3], 32'h7FFF_FF9B);
        repeat (4) send(-16'sd16384, 1'b0, 4'h2);
        drain();
        check("dev_down", obs0[7], 32'h0065_7FFF);
        repeat (3) send(16'h8000, 1'b0, 4'h4);
        drain();

        // Backpressure: output stalled for cycles 4-8 of a 10-beat stream
        do_reset();
        fork
            begin
                for (int i = 1; i <= 10; i++) begin
                    logic [15:0] xv;
                    xv = (i == 5) ? 16'h8000 : 16'(i * 3000 - 15000);
                    send(xv, i == 10, 4'(i));
                end
            end
            begin
                repeat (4) @(posedge clk);
                #2 m_rdy = 1'b0;
                repeat (5) @(posedge clk);
                #2 m_rdy = 1'b1;
            end
        join
        drain();
        check("bp_count", 32'(obs0.size()), 32'd10);

        // Asynchronous reset in the middle of a stream
        do_reset();
        send(16'd1000, 1'b0, 4'hF);
        send(16'd2000, 1'b0, 4'hF);
        send(16'd3000, 1'b0, 4'hF);
        @(posedge clk);
        #2 check("pre_rst_vld", {31'b0, m_vld0}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_m_vld", {31'b0, m_vld0}, 32'd0);
        check("arst_m_vld1", {31'b0, m_vld1}, 32'd0);
        check("arst_m_dat", m_dat0, 32'd0);
        repeat (2) @(negedge clk);
        clear_sb();
        rst_n = 1'b1;
        @(negedge clk);
        send(16'd0, 1'b1, 4'hF);
        drain();
        check("arst_after", obs0[0], 32'h0065_7FFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
